// File: rtl/mem_pkg.sv
// Shared encodings and lane-steering helpers for the data-memory controller.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StResp = 2'd2;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic res;
    res = 1'b0;
    if (size == SZ_HALF) begin
      res = off[0];
    end else if (size != SZ_BYTE) begin
      res = |off;
    end
    return res;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    mask = 4'b1111;
    if (size == SZ_BYTE) begin
      mask = 4'b0001 << off;
    end else if (size == SZ_HALF) begin
      mask = 4'b0011 << off;
    end
    return mask;
  endfunction

  // Replicate right-justified store data so every candidate lane carries it.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] res;
    res = wdata;
    if (size == SZ_BYTE) begin
      res = {4{wdata[7:0]}};
    end else if (size == SZ_HALF) begin
      res = {2{wdata[15:0]}};
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sext);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = word;
    if (size == SZ_BYTE) begin
      res = {{24{sext & sh[7]}}, sh[7:0]};
    end else if (size == SZ_HALF) begin
      res = {{16{sext & sh[15]}}, sh[15:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: req/ready handshake, lane steering, alignment check and
// configurable read latency in front of dmem_array.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        addr_err,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Last WAIT count before RESP; unreachable when RD_LAT == 1.
  localparam logic [1:0] LatLast = 2'(RD_LAT - 2);

  state_t      state_q, state_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        we_q, sext_q, err_q;
  logic [1:0]  size_q, off_q;

  logic        accept, acc_err;
  logic [3:0]  ram_be;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] load_word;

  logic        unused_addr;
  assign unused_addr = ^addr[31:IDX_W+2];

  assign accept  = (state_q == StIdle) & req;
  assign acc_err = misaligned(size, addr[1:0]);
  assign ram_be  = (accept & we & ~acc_err) ? byte_mask(size, addr[1:0]) : 4'b0000;
  assign ram_re  = accept & ~we & ~acc_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clka),
    .idx_i   (addr[IDX_W+1:2]),
    .be_i    (ram_be),
    .wdata_i (store_data(size, wdata)),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          lat_cnt_d = 2'd0;
          state_d   = (we | acc_err | (RD_LAT == 1)) ? StResp : StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q == LatLast) begin
          state_d = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      lat_cnt_q <= 2'd0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      off_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (accept) begin
        we_q   <= we;
        sext_q <= sign_ext;
        err_q  <= acc_err;
        size_q <= size;
        off_q  <= addr[1:0];
      end
    end
  end

  // The RAM output holds between reads, so the delay line only needs to shift.
  if (RD_LAT == 1) begin : g_no_pipe
    assign load_word = ram_rdata;
  end else begin : g_pipe
    logic [31:0] pipe_q [RD_LAT-1];
    always_ff @(posedge clka) begin
      pipe_q[0] <= ram_rdata;
      for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign load_word = pipe_q[RD_LAT-2];
  end

  assign ready    = (state_q == StResp);
  assign busy     = (state_q != StIdle);
  assign addr_err = ready & err_q;
  assign stall    = req & ~ready;
  assign rdata    = (ready & ~we_q & ~err_q) ? load_extract(load_word, size_q, off_q, sext_q)
                                             : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl across three latency/depth configurations.
module tb_data_mem_ctrl;

  localparam int NDUT = 3;

  function automatic int unsigned lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  function automatic int unsigned depth_of(input int g);
    return (g == 2) ? 256 : 1024;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [NDUT];
  logic        we    [NDUT];
  logic        sext  [NDUT];
  logic [1:0]  size  [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic [31:0] rdata [NDUT];
  logic        ready [NDUT];
  logic        stall [NDUT];
  logic        aerr  [NDUT];
  logic        busy  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_ctrl #(
      .DEPTH  (depth_of(g)),
      .RD_LAT (lat_of(g))
    ) u_dut (
      .clka     (clk),
      .rst      (rst_n),
      .req      (req[g]),
      .we       (we[g]),
      .size     (size[g]),
      .sign_ext (sext[g]),
      .addr     (addr[g]),
      .wdata    (wdata[g]),
      .rdata    (rdata[g]),
      .ready    (ready[g]),
      .stall    (stall[g]),
      .addr_err (aerr[g]),
      .busy     (busy[g])
    );
  end

  typedef struct {
    int          g;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n_done = 0;
  int          cyc = 0;
  logic [7:0]  ref_mem [NDUT][4096];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, pops one expectation per ready pulse.
  exp_t e_mon;
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (stall[g] !== (req[g] & ~ready[g])) begin
        errors++;
        $display("FAIL stall dut%0d: got %b want %b", g, stall[g], req[g] & ~ready[g]);
      end
      if (ready[g] !== 1'b1) begin
        checks++;
        if (aerr[g] !== 1'b0) begin
          errors++;
          $display("FAIL addr_err_idle dut%0d: got %b want 0", g, aerr[g]);
        end
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready dut%0d at cycle %0d", g, cyc);
      end else begin
        e_mon = sb.pop_front();
        checks += 4;
        if (e_mon.g != g) begin
          errors++;
          $display("FAIL ready_source: got dut%0d want dut%0d", g, e_mon.g);
        end
        if (rdata[g] !== e_mon.rdata) begin
          errors++;
          $display("FAIL rdata dut%0d: got %h want %h", g, rdata[g], e_mon.rdata);
        end
        if (aerr[g] !== e_mon.err) begin
          errors++;
          $display("FAIL addr_err dut%0d: got %b want %b", g, aerr[g], e_mon.err);
        end
        if (cyc != e_mon.cyc) begin
          errors++;
          $display("FAIL latency dut%0d: ready at cycle %0d want %0d", g, cyc, e_mon.cyc);
        end
        n_done++;
      end
    end
  end

  // One access: model it at byte level, push the expectation, drive and wait.
  task automatic access(input int g, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    int          nb, ba, target;
    logic        mis, done;
    logic [31:0] v;
    exp_t        e;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis = (a % 32'(nb)) != 32'd0;
    ba  = int'(a % 32'(4 * depth_of(g)));
    e.g     = g;
    e.err   = mis;
    e.rdata = 32'd0;
    e.cyc   = cyc + ((mis || w) ? 1 : int'(lat_of(g)));
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[g][ba+i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[g][ba+i]) << (8 * i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        e.rdata = v;
      end
    end
    req[g]   = 1'b1;
    we[g]    = w;
    size[g]  = sz;
    sext[g]  = sx;
    addr[g]  = a;
    wdata[g] = d;
    target   = n_done + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Inputs after acceptance must not matter; req may even be dropped.
    we[g]    = 1'($urandom);
    size[g]  = 2'($urandom);
    sext[g]  = 1'($urandom);
    addr[g]  = $urandom;
    wdata[g] = $urandom;
    if ($urandom_range(3) == 0) req[g] = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (n_done == target) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout dut%0d addr %h: no ready within budget", g, a);
      sb.delete();
      n_done = target;
    end
    req[g] = 1'b0;
  endtask

  int          start_done;
  int          sh;
  logic [31:0] ra;

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      req[g] = 1'b0; we[g] = 1'b0; size[g] = 2'b00; sext[g] = 1'b0;
      addr[g] = 32'd0; wdata[g] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (ready[g] !== 1'b0 || busy[g] !== 1'b0 || aerr[g] !== 1'b0 || rdata[g] !== 32'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ready=%b busy=%b addr_err=%b rdata=%h want all 0",
                 g, ready[g], busy[g], aerr[g], rdata[g]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed sequence on the RD_LAT=2 instance.
    access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    access(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h55);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    access(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_8000);
    access(1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    access(1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    access(1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    access(1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
    access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // Address wrap on the DEPTH=256 instance.
    access(2, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_0F0F);
    access(2, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0);

    // Reset one cycle into WAIT of a load: the access is aborted silently.
    req[2] = 1'b1; we[2] = 1'b0; size[2] = 2'b10; addr[2] = 32'h0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start_done = n_done;
    rst_n  = 1'b0;
    req[2] = 1'b0;
    #1;
    checks++;
    if (busy[2] !== 1'b0 || ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort dut2: busy=%b ready=%b want 0 0", busy[2], ready[2]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_done != start_done) begin
      errors++;
      $display("FAIL reset_no_ready dut2: %0d completions want 0", n_done - start_done);
    end
    access(2, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0);

    // Randomized traffic over a pre-filled window, with junk in the ignored upper bits.
    for (int g = 0; g < NDUT; g++) begin
      for (int w = 0; w < 64; w++) access(g, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);
      sh = $clog2(4 * depth_of(g));
      repeat (60) begin
        ra = 32'($urandom_range(255)) | ($urandom << sh);
        access(g, 1'($urandom_range(2) == 0), 2'($urandom), 1'($urandom), ra, $urandom);
      end
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
